ikascc_waveram_arb: RTL and testbench

IKASCC_WAVERAM_ARB -- requirements
Module: IKASCC_waveram_arb

---
 rtl/ikascc_waveram_arb.sv | 138 +++++++++++++
 tb/tb_ikascc_waveram_arb.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ikascc_waveram_arb.sv
// Wave-RAM slot arbiter: an 8-slot frame gives slots 0-4 to the sample channels and 5-7 to
// the CPU, with a two-enabled-cycle path from address issue to data capture.
module ikascc_waveram_arb #(
    parameter bit CPU_STEAL = 1'b1
) (
    input  logic        i_EMUCLK,
    input  logic        i_RST,
    input  logic        i_MCLK_PCEN_n,
    input  logic        i_CPU_WRRQ,
    input  logic        i_CPU_RDRQ,
    input  logic [6:0]  i_CPU_ADDR,
    input  logic [7:0]  i_CPU_DB,
    output logic [7:0]  o_CPU_DB,
    output logic        o_CPU_RDVALID,
    output logic        o_CPU_BUSY,
    input  logic [4:0]  i_CH_REQ,
    input  logic [24:0] i_CH_PTR,
    output logic [39:0] o_CH_SAMPLE,
    output logic [4:0]  o_CH_ACK,
    output logic [6:0]  o_RAM_ADDR,
    output logic [7:0]  o_RAM_DI,
    output logic        o_RAM_WE,
    input  logic [7:0]  i_RAM_DO
);

    typedef enum logic [1:0] {TAG_NONE, TAG_CH, TAG_RD, TAG_WR} tag_t;

    logic       cen;
    logic [2:0] slot_reg;
    logic       pend_reg;
    logic       op_wr_reg;
    logic [6:0] op_addr_reg;
    logic [7:0] op_data_reg;
    tag_t       tag1_reg;
    tag_t       tag2_reg;
    logic [2:0] tag1_ch_reg;
    logic [2:0] tag2_ch_reg;

    logic [4:0] ch_ptr [8];
    logic [7:0] ch_req_ext;
    logic       slot_is_ch;
    logic       ch_take;
    logic       cpu_take;
    logic       busy_clear;
    logic       cpu_accept;
    logic [1:0] wave_sel;

    assign cen = ~i_MCLK_PCEN_n;

    // Per-slot pointer table; CPU slots read a zero pointer that is never used.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ptr
            if (gi < 5) begin : g_ch
                assign ch_ptr[gi] = i_CH_PTR[5*gi +: 5];
            end else begin : g_pad
                assign ch_ptr[gi] = 5'd0;
            end
        end
    endgenerate

    always_comb begin
        ch_req_ext = {3'b000, i_CH_REQ};
        slot_is_ch = (slot_reg < 3'd5);
        ch_take    = ch_req_ext[slot_reg];
        cpu_take   = pend_reg && !ch_take && (!slot_is_ch || CPU_STEAL);
        wave_sel   = (slot_reg == 3'd4) ? 2'd3 : slot_reg[1:0];
        // Writes retire one cycle after issue, reads when their data is captured.
        busy_clear = (tag1_reg == TAG_WR) || (tag2_reg == TAG_RD);
        cpu_accept = (!o_CPU_BUSY || busy_clear) && (i_CPU_WRRQ || i_CPU_RDRQ);
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            slot_reg      <= 3'd0;
            pend_reg      <= 1'b0;
            op_wr_reg     <= 1'b0;
            op_addr_reg   <= 7'd0;
            op_data_reg   <= 8'd0;
            tag1_reg      <= TAG_NONE;
            tag2_reg      <= TAG_NONE;
            tag1_ch_reg   <= 3'd0;
            tag2_ch_reg   <= 3'd0;
            o_CPU_DB      <= 8'd0;
            o_CPU_RDVALID <= 1'b0;
            o_CPU_BUSY    <= 1'b0;
            o_CH_SAMPLE   <= 40'd0;
            o_CH_ACK      <= 5'd0;
            o_RAM_ADDR    <= 7'd0;
            o_RAM_DI      <= 8'd0;
            o_RAM_WE      <= 1'b0;
        end else if (cen) begin
            slot_reg      <= slot_reg + 3'd1;
            o_CPU_RDVALID <= 1'b0;
            o_CH_ACK      <= 5'd0;

            if (ch_take) begin
                o_RAM_ADDR  <= {wave_sel, ch_ptr[slot_reg]};
                o_RAM_WE    <= 1'b0;
                tag1_reg    <= TAG_CH;
                tag1_ch_reg <= slot_reg;
            end else if (cpu_take) begin
                o_RAM_ADDR  <= op_addr_reg;
                o_RAM_DI    <= op_data_reg;
                o_RAM_WE    <= op_wr_reg;
                tag1_reg    <= op_wr_reg ? TAG_WR : TAG_RD;
                pend_reg    <= 1'b0;
            end else begin
                o_RAM_WE    <= 1'b0;
                tag1_reg    <= TAG_NONE;
            end

            tag2_reg    <= tag1_reg;
            tag2_ch_reg <= tag1_ch_reg;

            if (tag2_reg == TAG_CH) begin
                o_CH_SAMPLE[{tag2_ch_reg, 3'b000} +: 8] <= i_RAM_DO;
                o_CH_ACK <= 5'd1 << tag2_ch_reg;
            end
            if (tag2_reg == TAG_RD) begin
                o_CPU_DB      <= i_RAM_DO;
                o_CPU_RDVALID <= 1'b1;
            end

            if (busy_clear)
                o_CPU_BUSY <= 1'b0;
            // A write request wins over a simultaneous read.
            if (cpu_accept) begin
                op_wr_reg   <= i_CPU_WRRQ;
                op_addr_reg <= i_CPU_ADDR;
                op_data_reg <= i_CPU_DB;
                pend_reg    <= 1'b1;
                o_CPU_BUSY  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ikascc_waveram_arb.sv
// Bench for ikascc_waveram_arb: time-stamped access model checked every clock, plus directed
// literal checks; a second instance with stealing disabled covers the slot-5 issue case.
module tb_ikascc_waveram_arb;

    localparam int K_CH = 0;
    localparam int K_RD = 1;
    localparam int K_WR = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, pcen_n, wrrq, rdrq;
    logic [6:0]  cpu_addr;
    logic [7:0]  cpu_db_in;
    logic [4:0]  ch_req;
    logic [24:0] ch_ptr;

    logic [7:0]  cpu_db, ram_di, ram_do;
    logic        rdvalid, busy, ram_we;
    logic [39:0] sample;
    logic [4:0]  ack;
    logic [6:0]  ram_addr;

    logic [7:0]  cpu_db0, ram_di0, ram_do0;
    logic        rdvalid0, busy0, ram_we0;
    logic [39:0] sample0;
    logic [4:0]  ack0;
    logic [6:0]  ram_addr0;

    ikascc_waveram_arb #(.CPU_STEAL(1'b1)) dut (
        .i_EMUCLK(clk), .i_RST(rst), .i_MCLK_PCEN_n(pcen_n),
        .i_CPU_WRRQ(wrrq), .i_CPU_RDRQ(rdrq), .i_CPU_ADDR(cpu_addr), .i_CPU_DB(cpu_db_in),
        .o_CPU_DB(cpu_db), .o_CPU_RDVALID(rdvalid), .o_CPU_BUSY(busy),
        .i_CH_REQ(ch_req), .i_CH_PTR(ch_ptr), .o_CH_SAMPLE(sample), .o_CH_ACK(ack),
        .o_RAM_ADDR(ram_addr), .o_RAM_DI(ram_di), .o_RAM_WE(ram_we), .i_RAM_DO(ram_do)
    );

    ikascc_waveram_arb #(.CPU_STEAL(1'b0)) dut0 (
        .i_EMUCLK(clk), .i_RST(rst), .i_MCLK_PCEN_n(pcen_n),
        .i_CPU_WRRQ(wrrq), .i_CPU_RDRQ(rdrq), .i_CPU_ADDR(cpu_addr), .i_CPU_DB(cpu_db_in),
        .o_CPU_DB(cpu_db0), .o_CPU_RDVALID(rdvalid0), .o_CPU_BUSY(busy0),
        .i_CH_REQ(ch_req), .i_CH_PTR(ch_ptr), .o_CH_SAMPLE(sample0), .o_CH_ACK(ack0),
        .o_RAM_ADDR(ram_addr0), .o_RAM_DI(ram_di0), .o_RAM_WE(ram_we0), .i_RAM_DO(ram_do0)
    );

    function automatic logic [7:0] pat(input int a);
        return (a == 'h47) ? 8'hA5 : 8'((a * 37 + 11) & 255);
    endfunction

    // Synchronous wave RAMs sharing the enable; unwritten bytes read the fixed pattern.
    bit       ram_w1 [128];
    bit [7:0] ram_d1 [128];
    bit       ram_w0 [128];
    bit [7:0] ram_d0 [128];
    always @(posedge clk) begin
        if (!pcen_n) begin
            if (ram_we) begin
                ram_w1[ram_addr] <= 1'b1;
                ram_d1[ram_addr] <= ram_di;
            end
            ram_do <= ram_w1[ram_addr] ? ram_d1[ram_addr] : pat(int'(ram_addr));
            if (ram_we0) begin
                ram_w0[ram_addr0] <= 1'b1;
                ram_d0[ram_addr0] <= ram_di0;
            end
            ram_do0 <= ram_w0[ram_addr0] ? ram_d0[ram_addr0] : pat(int'(ram_addr0));
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        pcen_n = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            pcen_n = (cyc % 3 == 2);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: every RAM access is a record stamped with its issue cycle; it hits
    // the RAM one enabled cycle later and its data is delivered two enabled cycles later.
    typedef struct {
        int t;
        int kind;
        int ch;
        int addr;
        int data;
        int val;
    } acc_t;

    acc_t       acc_q[$];
    int         mem [128];
    int         m_n, m_slot, m_op_addr, m_op_data;
    bit         m_pend, m_op_wr;
    logic [7:0] e_cpu_db, e_di;
    logic [6:0] e_addr;
    logic [4:0] e_ack;
    logic [7:0] e_sample [5];
    bit         e_rdvalid, e_busy, e_we;

    task automatic model_reset();
        acc_q.delete();
        m_n = 0; m_slot = 0; m_pend = 0; m_op_wr = 0; m_op_addr = 0; m_op_data = 0;
        e_cpu_db = 0; e_rdvalid = 0; e_busy = 0; e_ack = 0; e_addr = 0; e_di = 0; e_we = 0;
        foreach (e_sample[i]) e_sample[i] = 8'd0;
    endtask

    task automatic model_step();
        acc_t keep[$];
        int s, w;
        e_ack = 5'd0;
        e_rdvalid = 0;
        foreach (acc_q[i]) begin
            if (acc_q[i].t == m_n - 1) begin
                if (acc_q[i].kind == K_WR) begin
                    mem[acc_q[i].addr] = acc_q[i].data;
                    e_busy = 0;
                end else begin
                    acc_q[i].val = mem[acc_q[i].addr];
                end
            end else if (acc_q[i].t == m_n - 2) begin
                if (acc_q[i].kind == K_CH) begin
                    e_sample[acc_q[i].ch] = 8'(acc_q[i].val);
                    e_ack[acc_q[i].ch] = 1'b1;
                end else if (acc_q[i].kind == K_RD) begin
                    e_cpu_db = 8'(acc_q[i].val);
                    e_rdvalid = 1;
                    e_busy = 0;
                end
            end
            if (acc_q[i].t > m_n - 2) keep.push_back(acc_q[i]);
        end
        acc_q = keep;

        s = m_slot;
        if (s < 5 && ch_req[s]) begin
            w = (s == 4) ? 3 : s;
            e_addr = 7'(w * 32 + int'(ch_ptr[5*s +: 5]));
            e_we = 0;
            acc_q.push_back('{m_n, K_CH, s, int'(e_addr), 0, 0});
        end else if (m_pend && s >= 5 - 5) begin
            // Every slot not taken by its channel is open to the CPU when stealing is on.
            e_addr = 7'(m_op_addr);
            e_di = 8'(m_op_data);
            e_we = m_op_wr;
            acc_q.push_back('{m_n, m_op_wr ? K_WR : K_RD, 0, m_op_addr, m_op_data, 0});
            m_pend = 0;
        end else begin
            e_we = 0;
        end

        if (!e_busy && (wrrq || rdrq)) begin
            m_op_wr = wrrq;
            m_op_addr = int'(cpu_addr);
            m_op_data = int'(cpu_db_in);
            m_pend = 1;
            e_busy = 1;
        end
        m_slot = (m_slot + 1) % 8;
        m_n++;
    endtask

    initial begin
        for (int a = 0; a < 128; a++) mem[a] = int'(pat(a));
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else if (!pcen_n) model_step();
            #1;
            check("cyc_ram_addr", 64'(ram_addr), 64'(e_addr));
            check("cyc_ram_we", 64'(ram_we), 64'(e_we));
            if (e_we) check("cyc_ram_di", 64'(ram_di), 64'(e_di));
            check("cyc_busy", 64'(busy), 64'(e_busy));
            check("cyc_rdvalid", 64'(rdvalid), 64'(e_rdvalid));
            check("cyc_cpu_db", 64'(cpu_db), 64'(e_cpu_db));
            check("cyc_ch_ack", 64'(ack), 64'(e_ack));
            check("cyc_ch_sample", 64'(sample),
                  64'({e_sample[4], e_sample[3], e_sample[2], e_sample[1], e_sample[0]}));
        end
    end

    task automatic wait_en(input int k);
        for (int i = 0; i < k; i++) begin
            do @(posedge clk); while (pcen_n);
        end
        @(negedge clk);
    endtask

    task automatic wait_slot(input int s);
        int n;
        n = 0;
        while (m_slot != s && n < 16) begin
            wait_en(1);
            n++;
        end
        if (m_slot != s) check("wait_slot_timeout", 64'(m_slot), 64'(s));
    endtask

    task automatic wait_rdvalid();
        int n;
        n = 0;
        while (!rdvalid && n < 24) begin
            wait_en(1);
            n++;
        end
        check("rdvalid_seen", 64'(rdvalid), 64'd1);
    endtask

    task automatic count_window(input int k, output int we_cnt, output int rv_cnt);
        we_cnt = 0;
        rv_cnt = 0;
        for (int i = 0; i < k; i++) begin
            wait_en(1);
            we_cnt += int'(ram_we);
            rv_cnt += int'(rdvalid);
        end
    endtask

    task automatic cpu_req(input bit wr, input bit rd, input logic [6:0] a, input logic [7:0] d);
        wrrq = wr;
        rdrq = rd;
        cpu_addr = a;
        cpu_db_in = d;
        wait_en(1);
        wrrq = 1'b0;
        rdrq = 1'b0;
    endtask

    initial begin
        int we_cnt, rv_cnt;
        rst = 1'b1; wrrq = 1'b0; rdrq = 1'b0; cpu_addr = 7'd0; cpu_db_in = 8'd0;
        ch_req = 5'd0; ch_ptr = 25'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_we", 64'(ram_we), 64'd0);
        check("rst_addr", 64'(ram_addr), 64'd0);
        check("rst_sample", 64'(sample), 64'd0);
        rst = 1'b0;

        // Channel 2 fetch of wave 2, index 7
        ch_req = 5'b00100;
        ch_ptr[14:10] = 5'd7;
        wait_slot(2);
        wait_en(1);
        check("fetch_addr", 64'(ram_addr), 64'h47);
        check("model_fetch_addr", 64'(e_addr), 64'h47);
        wait_en(2);
        check("fetch_sample", 64'(sample[23:16]), 64'hA5);
        check("fetch_ack", 64'(ack), 64'b00100);
        wait_en(1);
        check("fetch_ack_once", 64'(ack), 64'd0);

        // Channel 4 shares wave 3
        ch_req = 5'b10000;
        ch_ptr[24:20] = 5'd31;
        wait_slot(4);
        wait_en(1);
        check("shared_addr", 64'(ram_addr), 64'h7F);
        wait_en(2);
        check("shared_sample", 64'(sample[39:32]), 64'h66);

        // CPU write with every channel requesting goes out in slot 5
        ch_req = 5'b11111;
        wait_slot(0);
        cpu_req(1'b1, 1'b0, 7'h10, 8'h3C);
        check("wr_busy_set", 64'(busy), 64'd1);
        wait_en(4);
        check("wr_not_yet", 64'(ram_we), 64'd0);
        wait_en(1);
        check("wr_we_slot5", 64'(ram_we), 64'd1);
        check("wr_addr", 64'(ram_addr), 64'h10);
        check("wr_di", 64'(ram_di), 64'h3C);
        wait_en(1);
        check("wr_busy_clr", 64'(busy), 64'd0);
        check("wr_we_once", 64'(ram_we), 64'd0);
        cpu_req(1'b0, 1'b1, 7'h10, 8'h00);
        wait_rdvalid();
        check("rd_data", 64'(cpu_db), 64'h3C);

        // Stealing: idle channels let the CPU in at slot 1; without stealing it waits for slot 5
        ch_req = 5'd0;
        wait_en(16);
        check("steal_idle", 64'(busy), 64'd0);
        check("nosteal_idle", 64'(busy0), 64'd0);
        wait_slot(0);
        cpu_req(1'b1, 1'b0, 7'h22, 8'h5A);
        wait_en(1);
        check("steal_we_slot1", 64'(ram_we), 64'd1);
        check("nosteal_we_slot1", 64'(ram_we0), 64'd0);
        wait_en(1);
        check("steal_busy_clr", 64'(busy), 64'd0);
        check("nosteal_busy", 64'(busy0), 64'd1);
        wait_en(2);
        check("nosteal_we_slot4", 64'(ram_we0), 64'd0);
        wait_en(1);
        check("nosteal_we_slot5", 64'(ram_we0), 64'd1);
        check("nosteal_addr", 64'(ram_addr0), 64'h22);
        wait_en(1);
        check("nosteal_busy_clr", 64'(busy0), 64'd0);

        // Write and read together: write only
        ch_req = 5'b11111;
        wait_en(16);
        wait_slot(0);
        cpu_req(1'b1, 1'b1, 7'h30, 8'h77);
        count_window(12, we_cnt, rv_cnt);
        check("both_we_count", 64'(we_cnt), 64'd1);
        check("both_no_rdvalid", 64'(rv_cnt), 64'd0);

        // Second request while busy is dropped
        wait_slot(0);
        cpu_req(1'b1, 1'b0, 7'h31, 8'h11);
        wait_en(1);
        cpu_req(1'b1, 1'b0, 7'h32, 8'h22);
        count_window(12, we_cnt, rv_cnt);
        check("busy_one_access", 64'(we_cnt), 64'd1);
        cpu_req(1'b0, 1'b1, 7'h32, 8'h00);
        wait_rdvalid();
        check("dropped_wr_data", 64'(cpu_db), 64'h45);
        cpu_req(1'b0, 1'b1, 7'h30, 8'h00);
        wait_rdvalid();
        check("both_wr_data", 64'(cpu_db), 64'h77);

        // Reset while a write is pending
        wait_slot(0);
        cpu_req(1'b1, 1'b0, 7'h40, 8'h99);
        wait_en(2);
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_we", 64'(ram_we), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ch_req = 5'b00001;
        ch_ptr[4:0] = 5'd9;
        wait_en(1);
        check("postrst_slot0", 64'(ram_addr), 64'h09);
        count_window(10, we_cnt, rv_cnt);
        check("postrst_no_we", 64'(we_cnt), 64'd0);
        cpu_req(1'b0, 1'b1, 7'h40, 8'h00);
        wait_rdvalid();
        check("postrst_old_data", 64'(cpu_db), 64'h4B);

        wait_en(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
